// File: rtl/x16_approx_mul.sv
// x16_approx_mul: registered 16x16 unsigned approximate multiplier.
// The product tree is built from 2x2 -> 4x4 -> 8x8 -> 16x16 cores. At each level
// the four sub-products are combined with adders whose low N bits are OR-ed
// rather than summed, and which have no carry from that low part.
// Optional feature macro: X16_APPROX_MUL_EXACT2X2_EN (exact 2x2 core, 3x3 = 9).
// Without the macro, the 2x2 core returns 7 for 3x3.
module x16_approx_mul #(
  parameter int N16 = 32,
  parameter int N8  = 16,
  parameter int N4  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [31:0] out
);

  // Reject out-of-range approximation widths at elaboration time.
  if (N16 < 0 || N16 > 32 || N8 < 0 || N8 > 16 || N4 < 0 || N4 > 8) begin : g_param_check
    $fatal(1, "x16_approx_mul: N16/N8/N4 out of range (0..32/0..16/0..8)");
  end

  // 2x2 core. The 3x3 case is the only one that needs a 4-bit result.
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
`ifdef X16_APPROX_MUL_EXACT2X2_EN
    return {2'b00, x} * {2'b00, y};
`else
    if (x == 2'd3 && y == 2'd3) begin
      return 4'd7;
    end
    return {2'b00, x} * {2'b00, y};
`endif
  endfunction

  // Approximate adders. Bits below m are x|y. Bits at and above m are the exact
  // sum of the upper parts, truncated to the adder width. A shift by m >= width
  // yields zero, which makes the m = width case a pure OR.
  function automatic logic [7:0] add8(input logic [7:0] x, input logic [7:0] y, input int m);
    logic [7:0] lo_mask;
    logic [7:0] hi;
    lo_mask = ~(8'hFF << m);
    hi      = ((x >> m) + (y >> m)) << m;
    return hi | ((x | y) & lo_mask);
  endfunction

  function automatic logic [15:0] add16(input logic [15:0] x, input logic [15:0] y, input int m);
    logic [15:0] lo_mask;
    logic [15:0] hi;
    lo_mask = ~(16'hFFFF << m);
    hi      = ((x >> m) + (y >> m)) << m;
    return hi | ((x | y) & lo_mask);
  endfunction

  function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y, input int m);
    logic [31:0] lo_mask;
    logic [31:0] hi;
    lo_mask = ~(32'hFFFF_FFFF << m);
    hi      = ((x >> m) + (y >> m)) << m;
    return hi | ((x | y) & lo_mask);
  endfunction

  // 4x4 level. The cross-term sum s1 fits in 5 bits, so s1<<2 fits in the 8-bit adder.
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] hh;
    logic [3:0] hl;
    logic [3:0] lh;
    logic [3:0] ll;
    logic [7:0] s1;
    hh = mul2(x[3:2], y[3:2]);
    hl = mul2(x[3:2], y[1:0]);
    lh = mul2(x[1:0], y[3:2]);
    ll = mul2(x[1:0], y[1:0]);
    s1 = add8({4'd0, hl}, {4'd0, lh}, N4);
    return add8({hh, ll}, s1 << 2, N4);
  endfunction

  // 8x8 level.
  function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0]  hh;
    logic [7:0]  hl;
    logic [7:0]  lh;
    logic [7:0]  ll;
    logic [15:0] s1;
    hh = mul4(x[7:4], y[7:4]);
    hl = mul4(x[7:4], y[3:0]);
    lh = mul4(x[3:0], y[7:4]);
    ll = mul4(x[3:0], y[3:0]);
    s1 = add16({8'd0, hl}, {8'd0, lh}, N8);
    return add16({hh, ll}, s1 << 4, N8);
  endfunction

  // 16x16 level.
  function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] hh;
    logic [15:0] hl;
    logic [15:0] lh;
    logic [15:0] ll;
    logic [31:0] s1;
    hh = mul8(x[15:8], y[15:8]);
    hl = mul8(x[15:8], y[7:0]);
    lh = mul8(x[7:0], y[15:8]);
    ll = mul8(x[7:0], y[7:0]);
    s1 = add32({16'd0, hl}, {16'd0, lh}, N16);
    return add32({hh, ll}, s1 << 8, N16);
  endfunction

  logic [31:0] prod;

  // Combinational approximate product of the current operands.
  always_comb begin
    prod = mul16(a, b);
  end

  // Output register. Valid follows in_valid; the result only updates on valid input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= prod;
      end
    end
  end

endmodule

// File: tb/tb_x16_approx_mul.sv
// Self-checking bench for x16_approx_mul.
// Three instances share the stimulus: the default (32,16,8), exact adders
// (0,0,0) and OR-only at the top level (32,0,0). Expected values come from an
// arithmetic reference model. Honours X16_APPROX_MUL_EXACT2X2_EN.
module tb_x16_approx_mul;

`ifdef X16_APPROX_MUL_EXACT2X2_EN
  localparam bit EXACT2 = 1'b1;
`else
  localparam bit EXACT2 = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        vld_def, vld_n0, vld_n16;
  logic [31:0] out_def, out_n0, out_n16;

  int checks   = 0;
  int failures = 0;

  longint unsigned exp_def, exp_n0, exp_n16;

  x16_approx_mul #(.N16(32), .N8(16), .N4(8)) dut_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(vld_def), .out(out_def)
  );

  x16_approx_mul #(.N16(0), .N8(0), .N4(0)) dut_n0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(vld_n0), .out(out_n0)
  );

  x16_approx_mul #(.N16(32), .N8(0), .N4(0)) dut_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(vld_n16), .out(out_n16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: adders described with division and modulo by powers of two.
  function automatic longint unsigned r_add(longint unsigned x, longint unsigned y, int m, int w);
    longint unsigned p, lo, hi;
    p  = 64'd1 << m;
    lo = (x % p) | (y % p);
    hi = (x / p + y / p) * p;
    return (hi + lo) % (64'd1 << w);
  endfunction

  // One level with k-bit halves: operand width 2k, adder width 4k.
  function automatic longint unsigned r_lvl(longint unsigned hh, longint unsigned hl,
                                            longint unsigned lh, longint unsigned ll,
                                            int k, int m);
    longint unsigned s1;
    s1 = r_add(hl, lh, m, 4 * k);
    return r_add(hh * (64'd1 << (2 * k)) + ll, s1 * (64'd1 << k), m, 4 * k);
  endfunction

  function automatic longint unsigned r2(longint unsigned x, longint unsigned y);
    if (x == 3 && y == 3 && !EXACT2) return 7;
    return x * y;
  endfunction

  function automatic longint unsigned r4(longint unsigned x, longint unsigned y, int n4);
    return r_lvl(r2(x / 4, y / 4), r2(x / 4, y % 4), r2(x % 4, y / 4), r2(x % 4, y % 4), 2, n4);
  endfunction

  function automatic longint unsigned r8(longint unsigned x, longint unsigned y, int n8, int n4);
    return r_lvl(r4(x / 16, y / 16, n4), r4(x / 16, y % 16, n4),
                 r4(x % 16, y / 16, n4), r4(x % 16, y % 16, n4), 4, n8);
  endfunction

  function automatic longint unsigned r16(longint unsigned x, longint unsigned y,
                                          int n16, int n8, int n4);
    return r_lvl(r8(x / 256, y / 256, n8, n4), r8(x / 256, y % 256, n8, n4),
                 r8(x % 256, y / 256, n8, n4), r8(x % 256, y % 256, n8, n4), 8, n16);
  endfunction

  // Drive one cycle of input, then sample all instances 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y);
    longint unsigned exact;
    in_valid = v;
    a        = x;
    b        = y;
    exact    = longint'(x) * longint'(y);
    if (v) begin
      exp_def = r16(x, y, 32, 16, 8);
      exp_n0  = r16(x, y, 0, 0, 0);
      exp_n16 = r16(x, y, 32, 0, 0);
    end
    @(posedge clk);
    #1;
    check("vld_def", vld_def, v);
    check("vld_n0",  vld_n0,  v);
    check("vld_n16", vld_n16, v);
    check("out_def", out_def, exp_def);
    check("out_n0",  out_n0,  exp_n0);
    check("out_n16", out_n16, exp_n16);
    if (v) begin
      check("le_exact_def", longint'(out_def) <= exact, 1);
      check("le_exact_n16", longint'(out_n16) <= exact, 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld_def"}, vld_def, 0);
    check({tag, "_vld_n0"},  vld_n0,  0);
    check({tag, "_vld_n16"}, vld_n16, 0);
    check({tag, "_out_def"}, out_def, 0);
    check({tag, "_out_n0"},  out_n0,  0);
    check({tag, "_out_n16"}, out_n16, 0);
  endtask

  initial begin
    logic [15:0] x, y;
    logic        v;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    exp_def  = 0;
    exp_n0   = 0;
    exp_n16  = 0;
    #2;
    check_all_zero("rst_init");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    step(1'b1, 16'd3, 16'd3);
    check("n0_3x3", out_n0, EXACT2 ? 32'd9 : 32'd7);
    step(1'b1, 16'd2, 16'd3);
    check("n0_2x3", out_n0, 32'd6);
    step(1'b1, 16'd0, 16'hFFFF);
    check("n0_0xffff", out_n0, 32'd0);
    check("def_0xffff", out_def, 32'd0);
    step(1'b1, 16'hBEEF, 16'd0);
    check("def_x0", out_def, 32'd0);
    check("n16_x0", out_n16, 32'd0);
    step(1'b1, 16'h0101, 16'h0101);
    check("n0_0101", out_n0, 32'h0001_0201);
    check("n16_0101", out_n16, 32'h0001_0101);
    step(1'b1, 16'hFFFF, 16'hFFFF);
    if (EXACT2) check("n0_ffff_exact", out_n0, 32'hFFFE_0001);
    step(1'b1, 16'h1234, 16'h5678);
    if (EXACT2) check("n0_1234_exact", out_n0, 32'h0626_0060);
    step(1'b0, 16'h5555, 16'hAAAA);
    check("hold_n0", out_n0, EXACT2 ? 32'h0626_0060 : exp_n0);

    // Throughput: ten back-to-back distinct operand pairs
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'h1111 * (i + 1)), 16'(16'h0F0F + 16'h0123 * i));
    end

    // Reset asserted mid-stream with in_valid high
    in_valid = 1'b1;
    a        = 16'hCAFE;
    b        = 16'h1357;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_wins");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("rst_release");
    exp_def = 0;
    exp_n0  = 0;
    exp_n16 = 0;
    step(1'b1, 16'hCAFE, 16'h1357);

    // Randomized operands, occasionally idle cycles and zero operands
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 7) != 0);
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 61 == 0) x = '0;
      if (i % 67 == 0) y = '0;
      if (i % 71 == 0) begin
        x = 16'hFFFF;
        y = 16'hFFFF;
      end
      step(v, x, y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
